avm_sram_arbiter: RTL and testbench



---
 rtl/avm_sram_arbiter.sv | 116 +++++++++++
 tb/tb_avm_sram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_sram_arbiter.sv
// Purpose: share one fixed-occupancy Avalon-MM SRAM controller between two hosts.
// Latency: read data returns 3 cycles after accept; writes complete on accept.
// Backpressure: waitrequest held high except for the winner in a free slot.
module avm_sram_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] h0_address,
    input  logic [3:0]  h0_byteenable,
    input  logic        h0_read,
    input  logic        h0_write,
    input  logic [31:0] h0_writedata,
    output logic        h0_waitrequest,
    output logic [31:0] h0_readdata,
    output logic        h0_readdatavalid,
    input  logic [17:0] h1_address,
    input  logic [3:0]  h1_byteenable,
    input  logic        h1_read,
    input  logic        h1_write,
    input  logic [31:0] h1_writedata,
    output logic        h1_waitrequest,
    output logic [31:0] h1_readdata,
    output logic        h1_readdatavalid,
    output logic [17:0] ctrl_address,
    output logic [3:0]  ctrl_byteenable,
    output logic        ctrl_read,
    output logic        ctrl_write,
    output logic [31:0] ctrl_writedata,
    input  logic [31:0] ctrl_readdata
);

    // Slot phases track the controller: DW0, DW1, then back to idle with data ready.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT1,
        S_WAIT2,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   pend_read;
    logic   pend_host;
    logic   req0;
    logic   req1;
    logic   slot_free;
    logic   grant_vld;
    logic   grant_host;
    logic   grant_wr;
    logic   sel_h1;

    // Arbitration and the combinational request mux toward the controller.
    always_comb begin
        req0       = h0_read | h0_write;
        req1       = h1_read | h1_write;
        slot_free  = reset_n && ((state == S_IDLE) || (state == S_DONE));
        grant_vld  = slot_free && (req0 || req1);
        if (req0 && req1) begin
            grant_host = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant;
        end else begin
            grant_host = ~req0;
        end
        // Write wins over a simultaneous read from the same host.
        grant_wr        = grant_host ? h1_write : h0_write;
        sel_h1          = grant_vld && grant_host;
        ctrl_address    = sel_h1 ? h1_address    : h0_address;
        ctrl_byteenable = sel_h1 ? h1_byteenable : h0_byteenable;
        ctrl_writedata  = sel_h1 ? h1_writedata  : h0_writedata;
        ctrl_write      = grant_vld && grant_wr;
        ctrl_read       = grant_vld && !grant_wr;
        h0_waitrequest  = !(grant_vld && !grant_host);
        h1_waitrequest  = !(grant_vld && grant_host);
    end

    // Next slot phase: a grant starts a 3-cycle occupancy.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = grant_vld ? S_WAIT1 : S_IDLE;
            S_WAIT1: state_nxt = S_WAIT2;
            S_WAIT2: state_nxt = S_DONE;
            S_DONE:  state_nxt = grant_vld ? S_WAIT1 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, round-robin pointer and pending-read bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            pend_read  <= 1'b0;
            pend_host  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                last_grant <= grant_host;
                pend_read  <= !grant_wr;
                pend_host  <= grant_host;
            end else if (state == S_DONE) begin
                pend_read  <= 1'b0;
            end
        end
    end

    // Response steering: controller data is passed through unregistered.
    always_comb begin
        h0_readdata      = ctrl_readdata;
        h1_readdata      = ctrl_readdata;
        h0_readdatavalid = reset_n && (state == S_DONE) && pend_read && !pend_host;
        h1_readdatavalid = reset_n && (state == S_DONE) && pend_read && pend_host;
    end

endmodule

// File: tb/tb_avm_sram_arbiter.sv
module tb_avm_sram_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Shared host-side stimulus, fed to both the round-robin and the priority instance.
    logic [1:0]  h_rd;
    logic [1:0]  h_wr;
    logic [1:0]  h_stream;
    logic [17:0] h_ad [2];
    logic [3:0]  h_be [2];
    logic [31:0] h_wd [2];

    logic        a_w0, a_w1, a_v0, a_v1, a_crd, a_cwr;
    logic [31:0] a_r0, a_r1, a_cwd;
    logic [17:0] a_cad;
    logic [3:0]  a_cbe;
    logic [31:0] a_crdata;

    logic        b_w0, b_w1, b_v0, b_v1, b_crd, b_cwr;
    logic [31:0] b_r0, b_r1, b_cwd;
    logic [17:0] b_cad;
    logic [3:0]  b_cbe;
    logic [31:0] b_crdata;
    assign b_crdata = 32'h0;

    avm_sram_arbiter #(.PRIORITY_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .h0_address(h_ad[0]), .h0_byteenable(h_be[0]), .h0_read(h_rd[0]),
        .h0_write(h_wr[0]), .h0_writedata(h_wd[0]), .h0_waitrequest(a_w0),
        .h0_readdata(a_r0), .h0_readdatavalid(a_v0),
        .h1_address(h_ad[1]), .h1_byteenable(h_be[1]), .h1_read(h_rd[1]),
        .h1_write(h_wr[1]), .h1_writedata(h_wd[1]), .h1_waitrequest(a_w1),
        .h1_readdata(a_r1), .h1_readdatavalid(a_v1),
        .ctrl_address(a_cad), .ctrl_byteenable(a_cbe), .ctrl_read(a_crd),
        .ctrl_write(a_cwr), .ctrl_writedata(a_cwd), .ctrl_readdata(a_crdata)
    );

    avm_sram_arbiter #(.PRIORITY_MODE(1)) dut_prio (
        .clk(clk), .reset_n(reset_n),
        .h0_address(h_ad[0]), .h0_byteenable(h_be[0]), .h0_read(h_rd[0]),
        .h0_write(h_wr[0]), .h0_writedata(h_wd[0]), .h0_waitrequest(b_w0),
        .h0_readdata(b_r0), .h0_readdatavalid(b_v0),
        .h1_address(h_ad[1]), .h1_byteenable(h_be[1]), .h1_read(h_rd[1]),
        .h1_write(h_wr[1]), .h1_writedata(h_wd[1]), .h1_waitrequest(b_w1),
        .h1_readdata(b_r1), .h1_readdatavalid(b_v1),
        .ctrl_address(b_cad), .ctrl_byteenable(b_cbe), .ctrl_read(b_crd),
        .ctrl_write(b_cwr), .ctrl_writedata(b_cwd), .ctrl_readdata(b_crdata)
    );

    // Behavioural SRAM controller for the round-robin instance: 3-cycle read pipe.
    logic [31:0] sram [1024];
    logic        sram_init = 1'b0;
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [9:0]  a1, a2;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
            sram_init <= 1'b1;
        end else if (!reset_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            if (a_cwr) begin
                for (int b = 0; b < 4; b++)
                    if (a_cbe[b]) sram[a_cad[9:0]][8*b +: 8] <= a_cwd[8*b +: 8];
            end
            p1 <= a_crd;
            a1 <= a_cad[9:0];
            p2 <= p1;
            a2 <= a1;
            if (p2) a_crdata <= sram[a2];
        end
    end

    // Reference model: slot availability as a cycle number, responses as a due-dated queue.
    typedef struct {
        int          inst;
        int          host;
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t        rq[$];
    logic [31:0] ref_mem [2][1024];
    int          m_last [2];
    int          m_free [2];
    bit          acc [2][2];
    int          cyc;
    int          n_chk, n_fail;
    int          last_rdv_cyc [2];
    logic [31:0] last_data [2];
    int          rsp_cnt [2];
    int          gnt_cnt [2][2];
    int          last_acc_host;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic eval_inst(input int k);
        logic w0, w1, v0, v1, crd, cwr;
        logic [31:0] r0, r1;
        logic [53:0] cbus;
        logic ew [2];
        logic ev [2];
        logic [31:0] ed [2];
        logic ecrd, ecwr;
        int win;
        logic [17:0] wa;
        if (k == 0) begin
            w0 = a_w0; w1 = a_w1; v0 = a_v0; v1 = a_v1; crd = a_crd; cwr = a_cwr;
            r0 = a_r0; r1 = a_r1; cbus = {a_cad, a_cbe, a_cwd};
        end else begin
            w0 = b_w0; w1 = b_w1; v0 = b_v0; v1 = b_v1; crd = b_crd; cwr = b_cwr;
            r0 = b_r0; r1 = b_r1; cbus = {b_cad, b_cbe, b_cwd};
        end
        win = -1;
        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
        if (!reset_n) begin
            for (int j = rq.size() - 1; j >= 0; j--) if (rq[j].inst == k) rq.delete(j);
            m_last[k] = 1;
            m_free[k] = cyc + 1;
        end else begin
            for (int j = rq.size() - 1; j >= 0; j--) begin
                if (rq[j].inst == k && rq[j].due <= cyc) begin
                    if (rq[j].due == cyc) begin
                        ev[rq[j].host] = 1'b1;
                        ed[rq[j].host] = rq[j].data;
                    end
                    rq.delete(j);
                end
            end
            if (cyc >= m_free[k]) begin
                if ((h_rd[0] | h_wr[0]) && (h_rd[1] | h_wr[1]))
                    win = (k == 1) ? 0 : ((m_last[k] == 1) ? 0 : 1);
                else if (h_rd[0] | h_wr[0]) win = 0;
                else if (h_rd[1] | h_wr[1]) win = 1;
            end
        end
        ew[0] = !(win == 0);
        ew[1] = !(win == 1);
        ecwr = (win >= 0) && h_wr[win[0]];
        ecrd = (win >= 0) && !h_wr[win[0]];
        if (win == 1) chk($sformatf("i%0d_cbus c%0d", k, cyc), {10'h0, cbus}, {10'h0, h_ad[1], h_be[1], h_wd[1]});
        else          chk($sformatf("i%0d_cbus c%0d", k, cyc), {10'h0, cbus}, {10'h0, h_ad[0], h_be[0], h_wd[0]});
        chk($sformatf("i%0d_wait0 c%0d", k, cyc), {63'h0, w0}, {63'h0, ew[0]});
        chk($sformatf("i%0d_wait1 c%0d", k, cyc), {63'h0, w1}, {63'h0, ew[1]});
        chk($sformatf("i%0d_crd c%0d", k, cyc), {63'h0, crd}, {63'h0, ecrd});
        chk($sformatf("i%0d_cwr c%0d", k, cyc), {63'h0, cwr}, {63'h0, ecwr});
        chk($sformatf("i%0d_rdv0 c%0d", k, cyc), {63'h0, v0}, {63'h0, ev[0]});
        chk($sformatf("i%0d_rdv1 c%0d", k, cyc), {63'h0, v1}, {63'h0, ev[1]});
        if (k == 0) begin
            if (ev[0]) begin
                chk($sformatf("rdata0 c%0d", cyc), {32'h0, r0}, {32'h0, ed[0]});
                last_data[0] = r0; last_rdv_cyc[0] = cyc; rsp_cnt[0]++;
            end
            if (ev[1]) begin
                chk($sformatf("rdata1 c%0d", cyc), {32'h0, r1}, {32'h0, ed[1]});
                last_data[1] = r1; last_rdv_cyc[1] = cyc; rsp_cnt[1]++;
            end
        end
        acc[k][0] = (win == 0);
        acc[k][1] = (win == 1);
        if (win >= 0) begin
            gnt_cnt[k][win]++;
            if (k == 0) last_acc_host = win;
            m_last[k] = win;
            m_free[k] = cyc + 3;
            wa = h_ad[win];
            if (h_wr[win[0]]) begin
                for (int b = 0; b < 4; b++)
                    if (h_be[win][b]) ref_mem[k][wa[9:0]][8*b +: 8] = h_wd[win][8*b +: 8];
            end else begin
                rq.push_back('{k, win, cyc + 3, ref_mem[k][wa[9:0]]});
            end
        end
    endtask

    // One clock: check at edge+2, then advance and retire accepted requests.
    task automatic cycle();
        #1;
        eval_inst(0);
        eval_inst(1);
        cyc++;
        @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++)
            if (acc[0][h] && !h_stream[h]) begin
                h_rd[h] = 1'b0;
                h_wr[h] = 1'b0;
            end
    endtask

    task automatic req(input int h, input bit wr, input logic [17:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        h_rd[h] = !wr; h_wr[h] = wr; h_ad[h] = a; h_wd[h] = d; h_be[h] = be;
    endtask

    task automatic wait_acc(input int h, input string nm, output int t);
        bit got;
        got = 1'b0;
        t = -1;
        for (int i = 0; i < 12 && !got; i++) begin
            cycle();
            if (acc[0][h]) begin got = 1'b1; t = cyc - 1; end
        end
        if (!got) chk({nm, "_timeout"}, 64'h0, 64'h1);
    endtask

    task automatic drain(input int n);
        h_rd = '0; h_wr = '0; h_stream = '0;
        repeat (n) cycle();
    endtask

    typedef struct {
        logic r0, w0, r1, w1;
        logic ew0, ew1, erd, ewr;
        logic [17:0] eaddr;
    } vec_t;
    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t0;
        h_rd = '0; h_wr = '0; h_stream = '0;
        for (int h = 0; h < 2; h++) begin
            h_ad[h] = '0; h_be[h] = '0; h_wd[h] = '0;
            m_last[h] = 1; m_free[h] = 0; last_rdv_cyc[h] = -1; last_data[h] = '0;
            rsp_cnt[h] = 0;
            for (int g = 0; g < 2; g++) begin gnt_cnt[h][g] = 0; acc[h][g] = 1'b0; end
            for (int i = 0; i < 1024; i++) ref_mem[h][i] = 32'h0;
        end
        cyc = 0; n_chk = 0; n_fail = 0; last_acc_host = -1;
        tbl[0] = '{0, 0, 0, 0, 1, 1, 0, 0, 18'h11};
        tbl[1] = '{1, 0, 0, 0, 0, 1, 1, 0, 18'h11};
        tbl[2] = '{0, 0, 1, 0, 1, 0, 1, 0, 18'h22};
        tbl[3] = '{0, 0, 0, 1, 1, 0, 0, 1, 18'h22};
        tbl[4] = '{1, 1, 0, 0, 0, 1, 0, 1, 18'h11};
        tbl[5] = '{1, 0, 1, 0, 0, 1, 1, 0, 18'h11};
        tbl[6] = '{0, 1, 1, 0, 0, 1, 0, 1, 18'h11};

        @(posedge clk); #1;
        repeat (3) cycle();
        reset_n = 1'b1;

        // Table: first decision out of reset for each request combination.
        for (int v = 0; v < 7; v++) begin
            reset_n = 1'b0; cycle(); reset_n = 1'b1;
            h_rd[0] = tbl[v].r0; h_wr[0] = tbl[v].w0; h_rd[1] = tbl[v].r1; h_wr[1] = tbl[v].w1;
            h_ad[0] = 18'h11; h_ad[1] = 18'h22; h_be[0] = 4'hF; h_be[1] = 4'h5;
            h_wd[0] = 32'h0A0A0000 + v; h_wd[1] = 32'h0B0B0000 + v;
            #1;
            chk($sformatf("tbl%0d_wait0", v), {63'h0, a_w0}, {63'h0, tbl[v].ew0});
            chk($sformatf("tbl%0d_wait1", v), {63'h0, a_w1}, {63'h0, tbl[v].ew1});
            chk($sformatf("tbl%0d_crd", v), {63'h0, a_crd}, {63'h0, tbl[v].erd});
            chk($sformatf("tbl%0d_cwr", v), {63'h0, a_cwr}, {63'h0, tbl[v].ewr});
            chk($sformatf("tbl%0d_addr", v), {46'h0, a_cad}, {46'h0, tbl[v].eaddr});
            cycle();
            drain(3);
        end

        // Single read returning a known word, 3 cycles after accept.
        req(1, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
        wait_acc(1, "pre_wr", t);
        drain(3);
        req(0, 1'b0, 18'h00010, 32'h0, 4'hF);
        wait_acc(0, "sr_acc", t);
        drain(3);
        chk("sr_lat", 64'(last_rdv_cyc[0]), 64'(t + 3));
        chk("sr_data", {32'h0, last_data[0]}, 64'hDEADBEEF);

        // Simultaneous reads: h0 at T, h1 at T+3.
        req(1, 1'b1, 18'h00020, 32'hA5A5_0020, 4'hF); wait_acc(1, "pw20", t); drain(3);
        req(1, 1'b1, 18'h00040, 32'h5A5A_0040, 4'hF); wait_acc(1, "pw40", t); drain(3);
        req(0, 1'b0, 18'h00020, 32'h0, 4'hF);
        req(1, 1'b0, 18'h00040, 32'h0, 4'hF);
        wait_acc(0, "sim_h0", t0);
        wait_acc(1, "sim_h1", t);
        chk("sim_gap", 64'(t - t0), 64'd3);
        drain(4);
        chk("sim_h1_lat", 64'(last_rdv_cyc[1]), 64'(t0 + 6));
        chk("sim_h1_data", {32'h0, last_data[1]}, 64'h5A5A0040);

        // Continuous contention: 12 back-to-back slots, 6 responses each.
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        for (int i = 0; i < 2; i++) for (int g = 0; g < 2; g++) gnt_cnt[i][g] = 0;
        h_stream = 2'b11;
        req(0, 1'b0, 18'h00020, 32'h0, 4'hF);
        req(1, 1'b0, 18'h00040, 32'h0, 4'hF);
        repeat (36) cycle();
        drain(3);
        chk("cont_rsp0", 64'(rsp_cnt[0]), 64'd6);
        chk("cont_rsp1", 64'(rsp_cnt[1]), 64'd6);
        chk("prio_h0_gnts", 64'(gnt_cnt[1][0]), 64'd12);
        chk("prio_h1_starved", 64'(gnt_cnt[1][1]), 64'd0);

        // Priority instance: h1 gets the first free slot once h0 stops.
        gnt_cnt[1][1] = 0;
        h_stream = 2'b11;
        req(0, 1'b0, 18'h00020, 32'h0, 4'hF);
        req(1, 1'b0, 18'h00040, 32'h0, 4'hF);
        repeat (9) cycle();
        chk("prio_hold", 64'(gnt_cnt[1][1]), 64'd0);
        h_stream[0] = 1'b0; h_rd[0] = 1'b0;
        repeat (3) cycle();
        chk("prio_h1_after", 64'(gnt_cnt[1][1]), 64'd1);
        drain(4);

        // Write then read, full word and low-half byte enables.
        req(1, 1'b1, 18'h00100, 32'h12345678, 4'hF); wait_acc(1, "wr_full", t);
        req(0, 1'b0, 18'h00100, 32'h0, 4'hF); wait_acc(0, "rd_full", t);
        drain(3);
        chk("wr_rd_data", {32'h0, last_data[0]}, 64'h12345678);
        req(1, 1'b1, 18'h00100, 32'hAAAABBBB, 4'h3); wait_acc(1, "wr_half", t);
        req(0, 1'b0, 18'h00100, 32'h0, 4'hF); wait_acc(0, "rd_half", t);
        drain(3);
        chk("wr_be3_data", {32'h0, last_data[0]}, 64'h1234BBBB);

        // Reset in the middle of a read: response is dropped, host 0 wins afterwards.
        rsp_cnt[0] = 0;
        req(0, 1'b0, 18'h00010, 32'h0, 4'hF); wait_acc(0, "rst_acc", t);
        reset_n = 1'b0;
        repeat (3) cycle();
        chk("rst_no_rdv", 64'(rsp_cnt[0]), 64'd0);
        reset_n = 1'b1;
        req(0, 1'b0, 18'h00020, 32'h0, 4'hF);
        req(1, 1'b0, 18'h00040, 32'h0, 4'hF);
        last_acc_host = -1;
        cycle();
        chk("rst_first_h0", 64'(last_acc_host), 64'd0);
        drain(6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            for (int h = 0; h < 2; h++) begin
                if (!h_rd[h] && !h_wr[h] && $urandom_range(2) == 0) begin
                    h_wr[h] = 1'($urandom_range(1));
                    h_rd[h] = !h_wr[h] || 1'($urandom_range(1));
                    h_ad[h] = 18'($urandom_range(1023));
                    h_be[h] = 4'($urandom_range(15, 1));
                    h_wd[h] = $urandom;
                end
            end
            reset_n = ($urandom_range(80) != 0);
            cycle();
        end
        reset_n = 1'b1;
        drain(4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
